// File: rtl/quadrature_step_decoder_if.sv
// Quadrature decoder bus: enable/raw A-B/error clear in,
// step/direction/illegal strobes and error count out.
interface quadrature_step_decoder_if #(
  parameter int ERR_W = 8
);
  logic             enable;
  logic             a_in;
  logic             b_in;
  logic             err_clear;
  logic             step;
  logic             up;
  logic             illegal;
  logic [ERR_W-1:0] err_count;

  modport master (
    output enable,
    output a_in,
    output b_in,
    output err_clear,
    input  step,
    input  up,
    input  illegal,
    input  err_count
  );

  modport slave (
    input  enable,
    input  a_in,
    input  b_in,
    input  err_clear,
    output step,
    output up,
    output illegal,
    output err_count
  );
endinterface

// File: rtl/quadrature_step_decoder.sv
// Quadrature front end: sync + glitch filter on A/B,
// x4 decode to step/up strobes, illegal-jump error count.
module quadrature_step_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input logic                      clk,
  input logic                      reset,
  quadrature_step_decoder_if.slave bus
);

  localparam int CW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  logic [1:0]             sync_ab;

  logic [1:0]             filt_q;
  logic [1:0]             filt_d;
  logic [1:0][CW-1:0]     cnt_q;
  logic [1:0][CW-1:0]     cnt_d;

  logic [1:0]             prev_q;
  logic [1:0]             diff;
  logic                   dir;

  logic                   step_q;
  logic                   step_d;
  logic                   illegal_q;
  logic                   illegal_d;
  logic                   up_q;
  logic                   up_d;
  logic [ERR_W-1:0]       err_q;
  logic [ERR_W-1:0]       err_d;

  // Input synchronisers: plain shift chains per channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a_in};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b_in};
    end
  end

  assign sync_ab = {a_sync_q[SYNC_STAGES-1],
                    b_sync_q[SYNC_STAGES-1]};

  // Filter: level follows sync only after a full stable run
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_ab[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        filt_d[i] = sync_ab[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // Gray-code step: up when prev.A differs from cur.B
  assign diff = filt_q ^ prev_q;
  assign dir  = prev_q[1] ^ filt_q[0];

  // Decode next strobes, direction and error count
  always_comb begin
    step_d    = 1'b0;
    illegal_d = 1'b0;
    up_d      = up_q;
    err_d     = err_q;
    unique case (1'b1)
      (diff == 2'b00): begin
      end
      (diff == 2'b11): begin
        if (bus.enable) begin
          illegal_d = 1'b1;
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
        end
      end
      default: begin
        if (bus.enable) begin
          step_d = 1'b1;
          up_d   = dir;
        end
      end
    endcase
    if (bus.err_clear) begin
      err_d = '0;
    end
  end

  // Decoder state; prev tracks even while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q    <= '0;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      up_q      <= 1'b1;
      err_q     <= '0;
    end else begin
      prev_q    <= filt_q;
      step_q    <= step_d;
      illegal_q <= illegal_d;
      up_q      <= up_d;
      err_q     <= err_d;
    end
  end

  assign bus.step      = step_q;
  assign bus.illegal   = illegal_q;
  assign bus.up        = up_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench for quadrature_step_decoder:
// latency, direction, filtering, errors, enable, reset.
module tb_quadrature_step_decoder;

  logic clk = 1'b0;
  logic reset;

  int   n_cmp = 0;
  int   n_err = 0;

  int   steps;
  int   ills;
  int   first;
  logic first_up;
  logic last_up;
  int   cnt_model;
  int   tot;
  int   ti;
  int   s0;

  always #5 clk = ~clk;

  quadrature_step_decoder_if #(.ERR_W(8)) qif ();

  quadrature_step_decoder #(
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4),
    .ERR_W        (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (qif.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // Apply A/B at a falling edge, then watch n cycles
  task automatic drive(input logic [1:0] ab, input int n);
    qif.a_in = ab[1];
    qif.b_in = ab[0];
    steps = 0;
    ills  = 0;
    first = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (qif.step === 1'b1) begin
        if (steps == 0) begin
          first    = k;
          first_up = qif.up;
        end
        steps++;
        last_up = qif.up;
        cnt_model = qif.up ? (cnt_model + 1) % 16
                           : (cnt_model + 15) % 16;
      end
      if (qif.illegal === 1'b1) ills++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    qif.enable    = 1'b1;
    qif.a_in      = 1'b0;
    qif.b_in      = 1'b0;
    qif.err_clear = 1'b0;
    cnt_model     = 0;
    first_up      = 1'b1;
    last_up       = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_step", qif.step, 0);
    chk("rst_illegal", qif.illegal, 0);
    chk("rst_up", qif.up, 1);
    chk("rst_err", qif.err_count, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // up sequence 01,11,10,00
    drive(2'b01, 10);
    chk("t1_latency", first, 7);
    chk("t1_first_up", first_up, 1);
    tot = steps; ti = ills;
    drive(2'b11, 10); tot += steps; ti += ills;
    drive(2'b10, 10); tot += steps; ti += ills;
    drive(2'b00, 10); tot += steps; ti += ills;
    chk("t1_steps", tot, 4);
    chk("t1_illegal", ti, 0);
    chk("t1_up", qif.up, 1);
    chk("t1_counter", cnt_model, 4);

    // down sequence 10,11,01,00; counter wraps 0 -> 12
    cnt_model = 0;
    drive(2'b10, 10); tot = steps; ti = ills;
    drive(2'b11, 10); tot += steps; ti += ills;
    drive(2'b01, 10); tot += steps; ti += ills;
    drive(2'b00, 10); tot += steps; ti += ills;
    chk("t2_steps", tot, 4);
    chk("t2_illegal", ti, 0);
    chk("t2_up", qif.up, 0);
    chk("t2_counter", cnt_model, 12);

    // 3-cycle glitch on A is swallowed
    drive(2'b10, 3); tot = steps; ti = ills;
    drive(2'b00, 12); tot += steps; ti += ills;
    chk("t3_short_steps", tot, 0);
    chk("t3_short_illegal", ti, 0);

    // 4-cycle glitch on A passes: 00->10 is the
    // reverse direction, 10->00 the forward one
    drive(2'b10, 4); s0 = steps;
    drive(2'b00, 15);
    chk("t3_long_early", s0, 0);
    chk("t3_long_steps", steps, 2);
    chk("t3_long_first_up", first_up, 0);
    chk("t3_long_last_up", last_up, 1);
    chk("t3_long_illegal", ills, 0);

    // double transition 00 -> 11
    drive(2'b11, 10);
    chk("t4_illegal", ills, 1);
    chk("t4_steps", steps, 0);
    chk("t4_err1", qif.err_count, 1);
    chk("t4_up_kept", qif.up, 1);
    drive(2'b00, 10);
    chk("t4_err2", qif.err_count, 2);

    // 300 more illegal jumps saturate the counter
    ti = 0; tot = 0;
    for (int r = 0; r < 150; r++) begin
      drive(2'b11, 5); ti += ills; tot += steps;
      drive(2'b00, 5); ti += ills; tot += steps;
    end
    drive(2'b00, 10); ti += ills; tot += steps;
    chk("t4_sat_pulses", ti, 300);
    chk("t4_sat_steps", tot, 0);
    chk("t4_sat_err", qif.err_count, 255);

    // clear coincident with an illegal increment
    qif.a_in = 1'b1;
    qif.b_in = 1'b1;
    repeat (6) @(negedge clk);
    qif.err_clear = 1'b1;
    @(negedge clk);
    chk("t4_clr_pulse", qif.illegal, 1);
    chk("t4_clr_err", qif.err_count, 0);
    qif.err_clear = 1'b0;
    drive(2'b00, 10);
    chk("t4_after_clr", qif.err_count, 1);

    // disabled decode, then enable while resting
    qif.enable = 1'b0;
    drive(2'b01, 10); tot = steps; ti = ills;
    drive(2'b11, 10); tot += steps; ti += ills;
    drive(2'b10, 10); tot += steps; ti += ills;
    chk("t5_dis_steps", tot, 0);
    chk("t5_dis_illegal", ti, 0);
    qif.enable = 1'b1;
    drive(2'b10, 10);
    chk("t5_en_steps", steps, 0);
    chk("t5_err_kept", qif.err_count, 1);
    drive(2'b00, 10);
    chk("t5_live_steps", steps, 1);
    chk("t5_live_up", last_up, 1);

    // reset mid-sequence while 01 is being filtered
    drive(2'b10, 10);
    chk("t6_pre_up", last_up, 0);
    drive(2'b11, 10);
    qif.a_in = 1'b0;
    qif.b_in = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_step", qif.step, 0);
    chk("t6_rst_illegal", qif.illegal, 0);
    chk("t6_rst_up", qif.up, 1);
    chk("t6_rst_err", qif.err_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(2'b01, 20);
    chk("t6_post_steps", steps, 1);
    chk("t6_post_up", last_up, 1);
    chk("t6_post_illegal", ills, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
